// File: rtl/sprite_pkg.sv
// Shared sprite-rendering types: palette geometry, the 12-bit RGB triple,
// palette bank names and the response slot states.
package sprite_pkg;
   localparam int PAL_IDX_W = 4;
   localparam int COLOR_W   = 4;

   typedef struct packed {
      logic [COLOR_W-1:0] r;
      logic [COLOR_W-1:0] g;
      logic [COLOR_W-1:0] b;
   } rgb12_t;

   typedef enum logic [1:0] {BANK_UP, BANK_DOWN, BANK_LEFT, BANK_RIGHT} pal_bank_e;

   typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;
endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: grants the first active request at or after
// i_rr_ptr (wrapping mod N). Purely combinational.
module rr_priority_picker #(
   parameter int N    = 4,
   parameter int ID_W = $clog2(N)
) (
   input  logic [N-1:0]    i_req,
   input  logic [ID_W-1:0] i_rr_ptr,
   input  logic            i_en,
   output logic [N-1:0]    o_gnt,
   output logic [ID_W-1:0] o_gnt_id
);
   int w_sel;

   // Scan from farthest to nearest so the closest request to the pointer wins.
   always_comb begin
      o_gnt    = '0;
      o_gnt_id = '0;
      w_sel    = 0;
      for (int off = N - 1; off >= 0; off--) begin
         w_sel = (int'(i_rr_ptr) + off) % N;
         for (int k = 0; k < N; k++) begin
            if (k == w_sel && i_en && i_req[k]) begin
               o_gnt    = '0;
               o_gnt[k] = 1'b1;
               o_gnt_id = ID_W'(k);
            end
         end
      end
   end
endmodule

// File: rtl/palette_lookup_arbiter.sv
// Shares one combinational palette lookup among NUM_REQ pixel requesters with
// round-robin arbitration and a one-deep registered, backpressured response slot.
module palette_lookup_arbiter
   import sprite_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int BANK_W  = 2,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*4-1:0]      req_index,
   input  logic [NUM_REQ*BANK_W-1:0] req_bank,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [PAL_IDX_W-1:0]      pal_index,
   output logic [BANK_W-1:0]         pal_bank,
   input  logic [COLOR_W-1:0]        pal_red,
   input  logic [COLOR_W-1:0]        pal_green,
   input  logic [COLOR_W-1:0]        pal_blue,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [COLOR_W-1:0]        rsp_red,
   output logic [COLOR_W-1:0]        rsp_green,
   output logic [COLOR_W-1:0]        rsp_blue
);
   slot_state_e     r_state;
   logic [ID_W-1:0] r_rr_ptr;
   logic [ID_W-1:0] r_rsp_id;
   rgb12_t          r_rgb;

   logic            w_accept;
   logic            w_en;
   logic            w_granted;
   logic [ID_W-1:0] w_gnt_id;

   // Pointer arithmetic wraps at NUM_REQ, which need not be a power of two.
   function automatic logic [ID_W-1:0] f_next_ptr(input logic [ID_W-1:0] k);
      return (int'(k) == NUM_REQ - 1) ? '0 : k + 1'b1;
   endfunction

   assign w_accept  = (r_state == SLOT_EMPTY) || rsp_ready;
   assign w_en      = w_accept && !Reset;
   assign w_granted = |gnt;

   rr_priority_picker #(.N(NUM_REQ), .ID_W(ID_W)) u_picker (
      .i_req    (req),
      .i_rr_ptr (r_rr_ptr),
      .i_en     (w_en),
      .o_gnt    (gnt),
      .o_gnt_id (w_gnt_id)
   );

   always_comb begin
      pal_index = '0;
      pal_bank  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gnt[k]) begin
            pal_index = req_index[4*k +: 4];
            pal_bank  = req_bank[BANK_W*k +: BANK_W];
         end
      end
   end

   // A new grant overwrites the slot on the same edge the old response retires.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state  <= SLOT_EMPTY;
         r_rr_ptr <= '0;
         r_rsp_id <= '0;
         r_rgb    <= '0;
      end else begin
         if (w_granted) begin
            r_state  <= SLOT_FULL;
            r_rsp_id <= w_gnt_id;
            r_rgb    <= '{r: pal_red, g: pal_green, b: pal_blue};
            r_rr_ptr <= f_next_ptr(w_gnt_id);
         end else begin
            case (r_state)
               SLOT_EMPTY: r_state <= SLOT_EMPTY;
               SLOT_FULL:  r_state <= rsp_ready ? SLOT_EMPTY : SLOT_FULL;
               default:    r_state <= SLOT_EMPTY;
            endcase
         end
      end
   end

   assign rsp_valid = (r_state == SLOT_FULL);
   assign rsp_id    = r_rsp_id;
   assign rsp_red   = r_rgb.r;
   assign rsp_green = r_rgb.g;
   assign rsp_blue  = r_rgb.b;
endmodule
